// File: rtl/das_sum_engine.sv
// Delay-and-sum engine: per output sample t, fetches one delayed sample per channel and writes the exact sum.
// Build macro DAS_AVG_EN: each sum is divided by CHANNELS (shift by log2); CHANNELS must then be a power of two.
module das_sum_engine #(
  parameter int CHANNELS  = 8,
  parameter int SAMPLES   = 768,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 13,
  parameter int SIGNED_IN = 1,
  parameter int SUM_W     = DATA_W + $clog2(CHANNELS)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic [$clog2(CHANNELS*SAMPLES)-1:0] delay_addr,
  output logic                                delay_en,
  input  logic [ADDR_W-1:0]                   delay_data,
  output logic [ADDR_W-1:0]                   samp_addr,
  output logic                                samp_en,
  input  logic [DATA_W-1:0]                   samp_data,
  output logic [$clog2(SAMPLES)-1:0]          sum_addr,
  output logic [SUM_W-1:0]                    sum_data,
  output logic                                sum_we
);

  localparam int N    = CHANNELS * SAMPLES;
  localparam int DA_W = $clog2(N);
  localparam int T_W  = $clog2(SAMPLES);
  localparam int C_W  = $clog2(CHANNELS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] MASK_ENTRY = {ADDR_W{1'b1}};
  localparam logic [C_W-1:0]    C_LAST     = C_W'(CHANNELS - 1);
  localparam logic [T_W-1:0]    T_LAST     = T_W'(SAMPLES - 1);
  localparam logic [DA_W-1:0]   T_STRIDE   = DA_W'(SAMPLES);

`ifdef DAS_AVG_EN
  if ((1 << C_W) != CHANNELS) begin : g_avg_requires_pow2
    $error("das_sum_engine: DAS_AVG_EN requires a power-of-two CHANNELS");
  end
`endif

  // Issue side (stage 1)
  logic [1:0]      state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            delay_en_q, delay_en_d;
  logic [DA_W-1:0] delay_addr_q, delay_addr_d;
  logic [C_W-1:0]  c_q, c_d;
  logic [T_W-1:0]  t_q, t_d;
  logic            row_end, last_issue;

  // Stage 2 / stage 3 tags travelling with each request
  logic            s2_vld_q, s2_vld_d;
  logic [C_W-1:0]  s2_c_q, s2_c_d;
  logic [T_W-1:0]  s2_t_q, s2_t_d;
  logic            s2_msk;
  logic            s3_vld_q, s3_vld_d;
  logic            s3_msk_q, s3_msk_d;
  logic [C_W-1:0]  s3_c_q, s3_c_d;
  logic [T_W-1:0]  s3_t_q, s3_t_d;

  // Accumulate and write-back
  logic [SUM_W-1:0] acc_q, acc_d;
  logic             sum_we_q, sum_we_d;
  logic [T_W-1:0]   sum_addr_q, sum_addr_d;
  logic [SUM_W-1:0] sum_data_q, sum_data_d;
  logic             ext_bit;
  logic [SUM_W-1:0] samp_ext, contrib, acc_sum, sum_out;

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    delay_en_d   = delay_en_q;
    delay_addr_d = delay_addr_q;
    c_d          = c_q;
    t_d          = t_q;
    row_end      = (c_q == C_LAST);
    last_issue   = row_end && (t_q == T_LAST);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_RUN;
          busy_d       = 1'b1;
          delay_en_d   = 1'b1;
          delay_addr_d = '0;
          c_d          = '0;
          t_d          = '0;
        end
      end
      ST_RUN: begin
        // Walk t-major (n = t*CHANNELS + c) while the table is laid out c*SAMPLES + t.
        if (last_issue) begin
          state_d      = ST_DRAIN;
          delay_en_d   = 1'b0;
          delay_addr_d = '0;
          c_d          = '0;
          t_d          = '0;
        end else if (row_end) begin
          c_d          = '0;
          t_d          = t_q + T_W'(1);
          delay_addr_d = DA_W'(t_q) + DA_W'(1);
        end else begin
          c_d          = c_q + C_W'(1);
          delay_addr_d = delay_addr_q + T_STRIDE;
        end
      end
      ST_DRAIN: begin
        if (sum_we_q && (sum_addr_q == T_LAST)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Stage 2: the delay entry is the sample address; an all-ones entry masks the channel.
  assign s2_msk    = (delay_data == MASK_ENTRY);
  assign samp_en   = s2_vld_q && !s2_msk;
  assign samp_addr = samp_en ? delay_data : '0;

  always_comb begin
    s2_vld_d = delay_en_q;
    s2_c_d   = c_q;
    s2_t_d   = t_q;
    s3_vld_d = s2_vld_q;
    s3_msk_d = s2_msk;
    s3_c_d   = s2_c_q;
    s3_t_d   = s2_t_q;
  end

  always_comb begin
    ext_bit  = (SIGNED_IN != 0) && samp_data[DATA_W-1];
    samp_ext = {{(SUM_W-DATA_W){ext_bit}}, samp_data};
    contrib  = s3_msk_q ? '0 : samp_ext;
    acc_sum  = (s3_c_q == '0) ? contrib : acc_q + contrib;
`ifdef DAS_AVG_EN
    if (SIGNED_IN != 0) sum_out = $unsigned($signed(acc_sum) >>> C_W);
    else                sum_out = acc_sum >> C_W;
`else
    sum_out  = acc_sum;
`endif
    acc_d      = s3_vld_q ? acc_sum : acc_q;
    sum_we_d   = s3_vld_q && (s3_c_q == C_LAST);
    sum_addr_d = sum_we_d ? s3_t_q : sum_addr_q;
    sum_data_d = sum_we_d ? sum_out : sum_data_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      delay_en_q   <= 1'b0;
      delay_addr_q <= '0;
      c_q          <= '0;
      t_q          <= '0;
      s2_vld_q     <= 1'b0;
      s2_c_q       <= '0;
      s2_t_q       <= '0;
      s3_vld_q     <= 1'b0;
      s3_msk_q     <= 1'b0;
      s3_c_q       <= '0;
      s3_t_q       <= '0;
      acc_q        <= '0;
      sum_we_q     <= 1'b0;
      sum_addr_q   <= '0;
      sum_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      delay_en_q   <= delay_en_d;
      delay_addr_q <= delay_addr_d;
      c_q          <= c_d;
      t_q          <= t_d;
      s2_vld_q     <= s2_vld_d;
      s2_c_q       <= s2_c_d;
      s2_t_q       <= s2_t_d;
      s3_vld_q     <= s3_vld_d;
      s3_msk_q     <= s3_msk_d;
      s3_c_q       <= s3_c_d;
      s3_t_q       <= s3_t_d;
      acc_q        <= acc_d;
      sum_we_q     <= sum_we_d;
      sum_addr_q   <= sum_addr_d;
      sum_data_q   <= sum_data_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign delay_en   = delay_en_q;
  assign delay_addr = delay_addr_q;
  assign sum_we     = sum_we_q;
  assign sum_addr   = sum_addr_q;
  assign sum_data   = sum_data_q;

endmodule

// File: tb/tb_das_sum_engine.sv
// Scoreboard bench for das_sum_engine: a 4x4 identity/masking instance and two 8-channel all-ones instances.
// Expected sums follow the DAS_AVG_EN build when that macro is defined.
module tb_das_sum_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // 4-channel, 4-sample instance
  logic        start_a, busy_a, done_a, delay_en_a, samp_en_a, sum_we_a;
  logic [3:0]  delay_addr_a;
  logic [12:0] delay_data_a = '0;
  logic [12:0] samp_addr_a;
  logic [31:0] samp_data_a = '0;
  logic [1:0]  sum_addr_a;
  logic [33:0] sum_data_a;
  bit          mask_ch2 = 1'b0;

  // 8-channel, 4-sample instances (signed and unsigned)
  logic        start_8;
  logic        busy_s, done_s, delay_en_s, samp_en_s, sum_we_s;
  logic [4:0]  delay_addr_s;
  logic [12:0] delay_data_s = '0;
  logic [12:0] samp_addr_s;
  logic [31:0] samp_data_s = '0;
  logic [1:0]  sum_addr_s;
  logic [34:0] sum_data_s;
  logic        busy_u, done_u, delay_en_u, samp_en_u, sum_we_u;
  logic [4:0]  delay_addr_u;
  logic [12:0] delay_data_u = '0;
  logic [12:0] samp_addr_u;
  logic [31:0] samp_data_u = '0;
  logic [1:0]  sum_addr_u;
  logic [34:0] sum_data_u;

  das_sum_engine #(.CHANNELS(4), .SAMPLES(4), .DATA_W(32), .ADDR_W(13), .SIGNED_IN(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
    .delay_addr(delay_addr_a), .delay_en(delay_en_a), .delay_data(delay_data_a),
    .samp_addr(samp_addr_a), .samp_en(samp_en_a), .samp_data(samp_data_a),
    .sum_addr(sum_addr_a), .sum_data(sum_data_a), .sum_we(sum_we_a)
  );

  das_sum_engine #(.CHANNELS(8), .SAMPLES(4), .DATA_W(32), .ADDR_W(13), .SIGNED_IN(1)) dut_s (
    .clk(clk), .reset(reset), .start(start_8), .busy(busy_s), .done(done_s),
    .delay_addr(delay_addr_s), .delay_en(delay_en_s), .delay_data(delay_data_s),
    .samp_addr(samp_addr_s), .samp_en(samp_en_s), .samp_data(samp_data_s),
    .sum_addr(sum_addr_s), .sum_data(sum_data_s), .sum_we(sum_we_s)
  );

  das_sum_engine #(.CHANNELS(8), .SAMPLES(4), .DATA_W(32), .ADDR_W(13), .SIGNED_IN(0)) dut_u (
    .clk(clk), .reset(reset), .start(start_8), .busy(busy_u), .done(done_u),
    .delay_addr(delay_addr_u), .delay_en(delay_en_u), .delay_data(delay_data_u),
    .samp_addr(samp_addr_u), .samp_en(samp_en_u), .samp_data(samp_data_u),
    .sum_addr(sum_addr_u), .sum_data(sum_data_u), .sum_we(sum_we_u)
  );

  // Memory models with registered reads. Delay entry c*4+t equals its own address; sample value = address.
  always @(posedge clk) begin
    if (delay_en_a) delay_data_a <= (mask_ch2 && delay_addr_a[3:2] == 2'd2) ? 13'h1FFF : {9'd0, delay_addr_a};
    if (samp_en_a)  samp_data_a  <= {19'd0, samp_addr_a};
    if (delay_en_s) delay_data_s <= {8'd0, delay_addr_s};
    if (samp_en_s)  samp_data_s  <= 32'hFFFF_FFFF;
    if (delay_en_u) delay_data_u <= {8'd0, delay_addr_u};
    if (samp_en_u)  samp_data_u  <= 32'hFFFF_FFFF;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_val(input logic signed [63:0] raw, input int sw, input int sh, input bit sgn);
    logic signed [63:0] v;
    bit avg;
    avg = 1'b0;
`ifdef DAS_AVG_EN
    avg = 1'b1;
`endif
    v = raw;
    if (avg) v = sgn ? (v >>> sh) : $signed($unsigned(v) >> sh);
    return v & ((64'd1 << sw) - 64'd1);
  endfunction

  // Scoreboards and per-frame observations
  logic [63:0] qa_addr[$], qa_data[$], qs_addr[$], qs_data[$], qu_addr[$], qu_data[$];
  int a_s, a_we, a_first_we, a_last_we, a_last_busy, a_done, a_done_cyc, a_samp, a_bad_ch2;
  int e_s, s_we, s_done, s_done_cyc, u_we, u_done, u_done_cyc;

  always @(negedge clk) begin
    if (sum_we_a) begin
      a_we++;
      if (a_first_we < 0) a_first_we = cyc;
      a_last_we = cyc;
      if (qa_data.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_write: got t=%0d data 0x%0h, required no write", sum_addr_a, sum_data_a);
      end else begin
        check("a_sum_addr", 64'(sum_addr_a), qa_addr.pop_front());
        check("a_sum_data", 64'(sum_data_a), qa_data.pop_front());
      end
    end
    if (done_a) begin a_done++; a_done_cyc = cyc; end
    if (busy_a) a_last_busy = cyc;
    if (samp_en_a) begin
      a_samp++;
      if (mask_ch2 && ((cyc - a_s - 2) % 4) == 2) a_bad_ch2++;
    end
  end

  always @(negedge clk) begin
    if (sum_we_s) begin
      s_we++;
      if (qs_data.size() == 0) begin
        checks++; errors++;
        $display("FAIL s_unexpected_write: got t=%0d data 0x%0h, required no write", sum_addr_s, sum_data_s);
      end else begin
        check("s_sum_addr", 64'(sum_addr_s), qs_addr.pop_front());
        check("s_sum_data", 64'(sum_data_s), qs_data.pop_front());
      end
    end
    if (done_s) begin s_done++; s_done_cyc = cyc; end
    if (sum_we_u) begin
      u_we++;
      if (qu_data.size() == 0) begin
        checks++; errors++;
        $display("FAIL u_unexpected_write: got t=%0d data 0x%0h, required no write", sum_addr_u, sum_data_u);
      end else begin
        check("u_sum_addr", 64'(sum_addr_u), qu_addr.pop_front());
        check("u_sum_data", 64'(sum_data_u), qu_data.pop_front());
      end
    end
    if (done_u) begin u_done++; u_done_cyc = cyc; end
  end

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_a();
    a_we = 0; a_first_we = -1; a_last_we = -1; a_last_busy = -1;
    a_done = 0; a_done_cyc = -1; a_samp = 0; a_bad_ch2 = 0;
  endtask

  task automatic pulse_start_a();
    @(posedge clk); #1;
    start_a = 1'b1;
    a_s = cyc;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic frame_a(input bit msk, input bit extra, input string tag);
    logic [63:0] raw;
    mask_ch2 = msk;
    for (int t = 0; t < 4; t++) begin
      raw = msk ? 64'(16 + 3 * t) : 64'(24 + 4 * t);
      qa_addr.push_back(64'(t));
      qa_data.push_back(exp_val(raw, 34, 2, 1'b1));
    end
    clear_a();
    pulse_start_a();
    if (extra) begin
      wait_until(a_s + 5);  start_a = 1'b1;
      wait_until(a_s + 6);  start_a = 1'b0;
      wait_until(a_s + 10); start_a = 1'b1;
      wait_until(a_s + 11); start_a = 1'b0;
    end
    wait_until(a_s + 40);
    $display("frame %s: writes=%0d done_at=S+%0d", tag, a_we, a_done_cyc - a_s);
    check({tag, "_done_count"}, 64'(a_done), 64'd1);
    check({tag, "_done_cycle"}, 64'(a_done_cyc - a_s), 64'd20);
    check({tag, "_first_we_cycle"}, 64'(a_first_we - a_s), 64'd7);
    check({tag, "_last_busy_cycle"}, 64'(a_last_busy - a_s), 64'd19);
    check({tag, "_write_count"}, 64'(a_we), 64'd4);
    check({tag, "_pending"}, 64'(qa_data.size()), 64'd0);
    check({tag, "_samp_en_count"}, 64'(a_samp), msk ? 64'd12 : 64'd16);
    check({tag, "_samp_en_masked_slot"}, 64'(a_bad_ch2), 64'd0);
  endtask

  task automatic frame_8();
    for (int t = 0; t < 4; t++) begin
      qs_addr.push_back(64'(t));
      qs_data.push_back(exp_val(-64'sd8, 35, 3, 1'b1));
      qu_addr.push_back(64'(t));
      qu_data.push_back(exp_val(64'sh7_FFFF_FFF8, 35, 3, 1'b0));
    end
    s_we = 0; s_done = 0; s_done_cyc = -1; u_we = 0; u_done = 0; u_done_cyc = -1;
    @(posedge clk); #1;
    start_8 = 1'b1;
    e_s = cyc;
    @(posedge clk); #1;
    start_8 = 1'b0;
    wait_until(e_s + 60);
    $display("frame ch8: signed writes=%0d unsigned writes=%0d", s_we, u_we);
    check("s_done_cycle", 64'(s_done_cyc - e_s), 64'd36);
    check("s_write_count", 64'(s_we), 64'd4);
    check("u_done_cycle", 64'(u_done_cyc - e_s), 64'd36);
    check("u_write_count", 64'(u_we), 64'd4);
    check("u_done_count", 64'(u_done), 64'd1);
  endtask

  task automatic reset_mid();
    mask_ch2 = 1'b0;
    qa_addr.push_back(64'd0);
    qa_data.push_back(exp_val(64'sd24, 34, 2, 1'b1));
    clear_a();
    pulse_start_a();
    wait_until(a_s + 9);
    reset = 1'b0;
    wait_until(a_s + 10);
    @(negedge clk);
    check("mid_reset_outputs", {6'd0, busy_a, done_a, delay_en_a, samp_en_a, sum_we_a,
                                delay_addr_a, samp_addr_a, sum_addr_a, sum_data_a}, 64'd0);
    reset = 1'b1;
    wait_until(a_s + 40);
    $display("frame mid_reset: writes=%0d done=%0d", a_we, a_done);
    check("mid_reset_write_count", 64'(a_we), 64'd1);
    check("mid_reset_last_we", 64'(a_last_we - a_s), 64'd7);
    check("mid_reset_done_count", 64'(a_done), 64'd0);
    check("mid_reset_last_busy", 64'(a_last_busy - a_s), 64'd9);
    check("mid_reset_pending", 64'(qa_data.size()), 64'd0);
  endtask

  initial begin
    reset   = 1'b0;
    start_a = 1'b0;
    start_8 = 1'b0;
    clear_a();
    repeat (3) @(posedge clk);
    start_a = 1'b1;  // reset must win over start
    @(negedge clk);
    check("reset_outputs_a", {6'd0, busy_a, done_a, delay_en_a, samp_en_a, sum_we_a,
                              delay_addr_a, samp_addr_a, sum_addr_a, sum_data_a}, 64'd0);
    check("reset_outputs_s", {4'd0, busy_s, done_s, delay_en_s, samp_en_s, sum_we_s,
                              delay_addr_s, samp_addr_s, sum_addr_s, sum_data_s}, 64'd0);
    @(posedge clk); #1;
    start_a = 1'b0;
    reset = 1'b1;
    wait_until(cyc + 3);
    check("idle_after_reset_start", 64'(busy_a), 64'd0);
    frame_a(1'b0, 1'b0, "identity");
    frame_a(1'b0, 1'b1, "timing");
    frame_a(1'b1, 1'b0, "masked");
    frame_8();
    reset_mid();
    frame_a(1'b0, 1'b0, "after_reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
